tmds_channel_decoder: RTL and testbench

- Receive-side counterpart of the 10:1 TMDS channel serializer; one instance per TMDS lane.
- Takes 10-bit parallel words from an upstream 1:10 deserializer in the pixel-clock domain.
- Finds the word boundary with an internal bit-offset aligner that locks on TMDS control tokens.
- Decodes each aligned 10-bit symbol into 8-bit pixel data, or into 2 control bits plus a data-enable.

---
 rtl/tmds_channel_decoder.sv | 209 ++++++++++++++++++++
 tb/tb_tmds_channel_decoder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/tmds_channel_decoder.sv
// TMDS receive lane: word aligner plus 10b->8b symbol decoder.
// Incoming 10-bit words are re-framed at a selectable bit offset. A small FSM
// walks the offset until a run of control tokens lines up, then holds it while
// periodic blanking keeps confirming the alignment.
module tmds_channel_decoder #(
    parameter int LOCK_COUNT     = 8,
    parameter int SEARCH_TIMEOUT = 4096,
    parameter int LOSS_TIMEOUT   = 65536
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] data_in,
    output logic [7:0] data_out,
    output logic [1:0] ctrl,
    output logic       de,
    output logic       locked,
    output logic [3:0] bit_offset,
    output logic       slip_wrap
);

    localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
    localparam int SRCH_W = $clog2(SEARCH_TIMEOUT);
    localparam int LOSS_W = $clog2(LOSS_TIMEOUT);

    localparam logic [RUN_W-1:0]  RUN_FULL    = RUN_W'(LOCK_COUNT);
    localparam logic [SRCH_W-1:0] SEARCH_LAST = SRCH_W'(SEARCH_TIMEOUT - 1);
    localparam logic [LOSS_W-1:0] LOSS_LAST   = LOSS_W'(LOSS_TIMEOUT - 1);

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_SLIP   = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    // Pipeline and output registers
    logic [9:0]        prev_q, aligned_q, aligned_d;
    logic [7:0]        data_out_q, data_out_d;
    logic [1:0]        ctrl_q, ctrl_d;
    logic              de_q, de_d;

    // Alignment FSM registers
    logic [1:0]        state_q, state_d;
    logic [3:0]        offset_q, offset_d;
    logic              slip_wrap_q, slip_wrap_d;
    logic              slip_cnt_q, slip_cnt_d;
    logic              locked_q, locked_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic [SRCH_W-1:0] search_q, search_d;
    logic [LOSS_W-1:0] loss_q, loss_d;
    logic              run_clr;

    // Decode intermediates
    logic              is_tok;
    logic [1:0]        tok_ctrl;
    logic [9:0]        q;
    logic [7:0]        dec;
    logic [19:0]       window;

    // Re-frame the two most recent words at the current bit offset
    always_comb begin
        window    = {data_in, prev_q};
        aligned_d = 10'(window >> offset_q);
    end

    // Recognise the four control tokens in the aligned word
    always_comb begin
        is_tok   = 1'b1;
        tok_ctrl = 2'b00;
        case (aligned_q)
            10'b1101010100: tok_ctrl = 2'b00;
            10'b0010101011: tok_ctrl = 2'b01;
            10'b0101010100: tok_ctrl = 2'b10;
            10'b1010101011: tok_ctrl = 2'b11;
            default:        is_tok   = 1'b0;
        endcase
    end

    // Undo the transmitter's optional inversion and XOR/XNOR chaining
    always_comb begin
        q      = aligned_q[9] ? {aligned_q[9:8], ~aligned_q[7:0]} : aligned_q;
        dec    = 8'h00;
        dec[0] = q[0];
        for (int i = 1; i < 8; i++) begin
            dec[i] = q[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        end
    end

    // Output registers: tokens update ctrl only, data symbols update the byte only
    always_comb begin
        data_out_d = data_out_q;
        ctrl_d     = ctrl_q;
        if (is_tok) begin
            de_d   = 1'b0;
            ctrl_d = tok_ctrl;
        end else begin
            de_d       = 1'b1;
            data_out_d = dec;
        end
    end

    // Alignment FSM: search at an offset, slip on timeout, hold while blanking recurs
    always_comb begin
        state_d     = state_q;
        offset_d    = offset_q;
        slip_cnt_d  = slip_cnt_q;
        slip_wrap_d = 1'b0;
        search_d    = search_q;
        loss_d      = loss_q;
        run_clr     = 1'b0;
        case (state_q)
            ST_SEARCH: begin
                if (run_q == RUN_FULL) begin
                    state_d  = ST_LOCKED;
                    search_d = '0;
                    loss_d   = '0;
                end else if (search_q == SEARCH_LAST) begin
                    state_d    = ST_SLIP;
                    search_d   = '0;
                    slip_cnt_d = 1'b0;
                    run_clr    = 1'b1;
                end else begin
                    search_d = search_q + SRCH_W'(1);
                end
            end
            ST_SLIP: begin
                // Two cycles here let the re-framed word refill before counting resumes
                run_clr = 1'b1;
                if (!slip_cnt_q) begin
                    offset_d    = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
                    slip_wrap_d = (offset_q == 4'd9);
                    slip_cnt_d  = 1'b1;
                end else begin
                    slip_cnt_d = 1'b0;
                    state_d    = ST_SEARCH;
                    search_d   = '0;
                end
            end
            ST_LOCKED: begin
                if (run_q == RUN_FULL) begin
                    loss_d = '0;
                end else if (loss_q == LOSS_LAST) begin
                    state_d  = ST_SEARCH;
                    loss_d   = '0;
                    search_d = '0;
                    run_clr  = 1'b1;
                end else begin
                    loss_d = loss_q + LOSS_W'(1);
                end
            end
            default: begin
                state_d  = ST_SEARCH;
                search_d = '0;
                loss_d   = '0;
                run_clr  = 1'b1;
            end
        endcase
        locked_d = (state_q == ST_LOCKED);
    end

    // Consecutive-token run counter, saturating at the lock threshold
    always_comb begin
        if (run_clr || !is_tok) begin
            run_d = '0;
        end else if (run_q == RUN_FULL) begin
            run_d = run_q;
        end else begin
            run_d = run_q + RUN_W'(1);
        end
    end

    // All state registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q      <= '0;
            aligned_q   <= '0;
            data_out_q  <= '0;
            ctrl_q      <= '0;
            de_q        <= 1'b0;
            state_q     <= ST_SEARCH;
            offset_q    <= '0;
            slip_cnt_q  <= 1'b0;
            slip_wrap_q <= 1'b0;
            locked_q    <= 1'b0;
            run_q       <= '0;
            search_q    <= '0;
            loss_q      <= '0;
        end else begin
            prev_q      <= data_in;
            aligned_q   <= aligned_d;
            data_out_q  <= data_out_d;
            ctrl_q      <= ctrl_d;
            de_q        <= de_d;
            state_q     <= state_d;
            offset_q    <= offset_d;
            slip_cnt_q  <= slip_cnt_d;
            slip_wrap_q <= slip_wrap_d;
            locked_q    <= locked_d;
            run_q       <= run_d;
            search_q    <= search_d;
            loss_q      <= loss_d;
        end
    end

    assign data_out   = data_out_q;
    assign ctrl       = ctrl_q;
    assign de         = de_q;
    assign locked     = locked_q;
    assign bit_offset = offset_q;
    assign slip_wrap  = slip_wrap_q;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed bench for the TMDS lane decoder: reset, lock, decode latency,
// offset search, lock loss/relock, offset wrap and asynchronous reset.
module tb_tmds_channel_decoder;

    localparam logic [9:0] T00 = 10'b1101010100;
    localparam logic [9:0] T01 = 10'b0010101011;
    localparam logic [9:0] T10 = 10'b0101010100;
    localparam logic [9:0] W1  = 10'b0100000000;
    localparam logic [9:0] W2  = 10'b1011111111;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] data_in;
    logic [7:0] data_out;
    logic [1:0] ctrl;
    logic       de;
    logic       locked;
    logic [3:0] bit_offset;
    logic       slip_wrap;

    int n_assert = 0;
    int n_fail   = 0;

    tmds_channel_decoder #(
        .LOCK_COUNT    (8),
        .SEARCH_TIMEOUT(64),
        .LOSS_TIMEOUT  (256)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .data_out  (data_out),
        .ctrl      (ctrl),
        .de        (de),
        .locked    (locked),
        .bit_offset(bit_offset),
        .slip_wrap (slip_wrap)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] all_outs();
        return {data_out, ctrl, de, locked, bit_offset, slip_wrap};
    endfunction

    initial begin
        logic [9:0] w3;
        logic [9:0] t10v;
        logic [3:0] last_off;
        logic [3:0] max_off;
        logic [3:0] chg_val[4];
        int         chg_cyc[4];
        int         nchg;
        int         cyc;
        int         wraps;
        int         k;
        logic       wrap_from9;

        t10v = T10;
        w3   = {t10v[6:0], t10v[9:7]};

        // 1: reset held, then released with zero input
        reset   = 1'b0;
        data_in = 10'd0;
        repeat (3) @(negedge clk);
        chk("reset_hold_outputs", 32'(all_outs()), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("release_outputs", 32'(all_outs()), 32'd0);
        chk("release_de", 32'(de), 32'd0);

        // 2: aligned token stream locks on the 3rd edge after the 8th aligned token
        @(negedge clk);
        data_in = T00;
        repeat (11) @(negedge clk);
        chk("lock_not_early", 32'(locked), 32'd0);
        @(negedge clk);
        chk("lock_on_time", 32'(locked), 32'd1);
        chk("lock_de", 32'(de), 32'd0);
        chk("lock_ctrl", 32'(ctrl), 32'd0);
        chk("lock_offset", 32'(bit_offset), 32'd0);
        repeat (8) @(negedge clk);

        // 4: data symbol decode and 3-edge latency
        data_in = W1;
        @(negedge clk);
        data_in = W2;
        @(negedge clk);
        chk("latency_not_early", 32'(de), 32'd0);
        data_in = T01;
        @(negedge clk);
        chk("dec_w1_de", 32'(de), 32'd1);
        chk("dec_w1_data", 32'(data_out), 32'h00);
        chk("ctrl_held", 32'(ctrl), 32'd0);
        data_in = T00;
        @(negedge clk);
        chk("dec_w2_de", 32'(de), 32'd1);
        chk("dec_w2_data", 32'(data_out), 32'hFE);
        @(negedge clk);
        chk("tok01_de", 32'(de), 32'd0);
        chk("tok01_ctrl", 32'(ctrl), 32'd1);
        chk("data_held", 32'(data_out), 32'hFE);
        chk("still_locked", 32'(locked), 32'd1);

        // 3: stream rotated by 3 bits, offset search steps 1,2,3 then locks
        @(negedge clk);
        reset   = 1'b0;
        data_in = w3;
        @(negedge clk);
        reset    = 1'b1;
        last_off = 4'd0;
        nchg     = 0;
        wraps    = 0;
        cyc      = 0;
        for (int i = 0; i < 4; i++) begin
            chg_val[i] = 4'd0;
            chg_cyc[i] = 0;
        end
        while (!locked && cyc < 600) begin
            @(negedge clk);
            cyc++;
            if (slip_wrap) wraps++;
            if (bit_offset != last_off) begin
                if (nchg < 4) begin
                    chg_val[nchg] = bit_offset;
                    chg_cyc[nchg] = cyc;
                end
                nchg++;
                last_off = bit_offset;
            end
        end
        chk("search_locked", 32'(locked), 32'd1);
        chk("search_nchg", 32'(nchg), 32'd3);
        chk("search_step1", 32'(chg_val[0]), 32'd1);
        chk("search_step2", 32'(chg_val[1]), 32'd2);
        chk("search_step3", 32'(chg_val[2]), 32'd3);
        chk("search_interval_a", 32'(chg_cyc[1] - chg_cyc[0]), 32'd66);
        chk("search_interval_b", 32'(chg_cyc[2] - chg_cyc[1]), 32'd66);
        chk("search_no_wrap", 32'(wraps), 32'd0);
        chk("search_offset", 32'(bit_offset), 32'd3);
        chk("search_ctrl", 32'(ctrl), 32'd2);
        chk("search_de", 32'(de), 32'd0);

        // 5: data-only input drops lock after the loss timeout, tokens relock
        data_in = 10'd0;
        k = 0;
        while (locked && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("loss_dropped", 32'(locked), 32'd0);
        chk("loss_window", 32'(k >= 256 && k <= 264), 32'd1);
        chk("loss_offset_kept", 32'(bit_offset), 32'd3);
        data_in = w3;
        k = 0;
        while (!locked && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("relock", 32'(locked), 32'd1);
        chk("relock_offset", 32'(bit_offset), 32'd3);
        chk("relock_ctrl", 32'(ctrl), 32'd2);

        // 3b: data-only input at rotation 0 walks the offset through a 9->0 wrap
        @(negedge clk);
        reset   = 1'b0;
        data_in = 10'd0;
        @(negedge clk);
        reset      = 1'b1;
        last_off   = 4'd0;
        max_off    = 4'd0;
        wraps      = 0;
        wrap_from9 = 1'b0;
        cyc        = 0;
        while (!(wraps > 0 && bit_offset == 4'd5) && cyc < 1500) begin
            @(negedge clk);
            cyc++;
            if (bit_offset > max_off) max_off = bit_offset;
            if (slip_wrap) begin
                wraps++;
                wrap_from9 = (last_off == 4'd9) && (bit_offset == 4'd0);
            end
            last_off = bit_offset;
        end
        chk("wrap_count", 32'(wraps), 32'd1);
        chk("wrap_from9", 32'(wrap_from9), 32'd1);
        chk("offset_max", 32'(max_off), 32'd9);
        chk("reach_offset5", 32'(bit_offset), 32'd5);
        chk("search_data_de", 32'(de), 32'd1);
        chk("search_data_byte", 32'(data_out), 32'hFE);

        // 6: asynchronous reset between clock edges
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("async_outputs", 32'(all_outs()), 32'd0);
        chk("async_offset", 32'(bit_offset), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
